piso_bit_streamer: RTL and testbench

- Parallel-in, serial-out bit streamer that sits directly upstream of the serial sequence detector.
- Accepts parallel words over a valid/ready handshake and emits them one bit per clock on x, which drives the detector's serial input.
- Supports MSB- or LSB-first order, optional idle gap between words, and a count of completed words.

---
 rtl/piso_bit_streamer.sv | 150 +++++++++++++++
 tb/tb_piso_bit_streamer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_bit_streamer.sv
// piso_bit_streamer: parallel-in, serial-out bit streamer feeding the serial
// sequence detector. Words arrive over a valid/ready handshake and leave one
// bit per clock on x, with optional idle gap cycles between words and a
// wrapping count of fully shifted words.
module piso_bit_streamer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic [15:0]      words_sent
);

    localparam int             IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [3:0]     GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);
    localparam bit             NO_GAP   = (GAP == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   shreg;
    logic [IDX_W-1:0]   bit_idx;
    logic [3:0]         gap_cnt;

    logic               last_bit;
    logic               accept;
    logic               gap_done;
    logic               load_bit;
    logic [WIDTH-1:0]   load_rest;
    logic               next_bit;
    logic [WIDTH-1:0]   next_rest;

    // The final bit cycle of a word is the only place SHIFT can hand over.
    assign last_bit = (state == S_SHIFT) && (bit_idx == LAST_IDX);

    // Ready depends only on state and reset, never on x or x_valid.
    assign din_ready = rst && ((state == S_IDLE) || (last_bit && NO_GAP));

    assign accept   = din_valid && din_ready;
    assign gap_done = (state == S_GAP) && (gap_cnt == GAP_LAST);
    assign busy     = (state != S_IDLE);

    // Bit order selection: the first bit of a fresh word and the next bit of
    // the word in flight, plus the remaining shift register contents.
    always_comb begin
        load_bit  = din[0];
        load_rest = din >> 1;
        next_bit  = shreg[0];
        next_rest = shreg >> 1;
        if (MSB_FIRST) begin
            load_bit  = din[WIDTH-1];
            load_rest = din << 1;
            next_bit  = shreg[WIDTH-1];
            next_rest = shreg << 1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a same-cycle reload on the last bit keeps the stream
    // contiguous when there is no gap.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    if (accept) begin
                        state_next = S_SHIFT;
                    end else if (NO_GAP) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: load presents the first bit immediately, each later edge
    // advances one bit, and the line drops to 0 once the word is done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= '0;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            words_sent <= '0;
        end else begin
            if (accept) begin
                shreg   <= load_rest;
                bit_idx <= '0;
                x       <= load_bit;
                x_valid <= 1'b1;
            end else if ((state == S_SHIFT) && !last_bit) begin
                shreg   <= next_rest;
                bit_idx <= bit_idx + 1'b1;
                x       <= next_bit;
                x_valid <= 1'b1;
            end else if (last_bit) begin
                x       <= 1'b0;
                x_valid <= 1'b0;
            end

            if (last_bit) begin
                gap_cnt <= '0;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end

            if (last_bit) begin
                words_sent <= words_sent + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_piso_bit_streamer.sv
// tb_piso_bit_streamer: exercises three streamer configurations (MSB-first no
// gap, LSB-first no gap, MSB-first with a 3-cycle gap) with directed and
// randomized words against a word/position reference model.
module tb_piso_bit_streamer;

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic        vm, vl, vg;
    logic        rdy_m, x_m, xv_m, busy_m;
    logic        rdy_l, x_l, xv_l, busy_l;
    logic        rdy_g, x_g, xv_g, busy_g;
    logic [15:0] ws_m, ws_l, ws_g;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  m_word[2];
    int          m_pos[2];
    bit          m_act[2];
    logic [15:0] m_cnt[2];

    piso_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(vm), .din_ready(rdy_m),
        .x(x_m), .x_valid(xv_m), .busy(busy_m), .words_sent(ws_m)
    );

    piso_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(vl), .din_ready(rdy_l),
        .x(x_l), .x_valid(xv_l), .busy(busy_l), .words_sent(ws_l)
    );

    piso_bit_streamer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(3)) dut_g (
        .clk(clk), .rst(rst), .din(din), .din_valid(vg), .din_ready(rdy_g),
        .x(x_g), .x_valid(xv_g), .busy(busy_g), .words_sent(ws_g)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit number pos (0 = first sent) of a word for the given order.
    function automatic logic bit_of(input logic [7:0] w, input int pos, input bit msb);
        return msb ? w[7 - pos] : w[pos];
    endfunction

    // Hold reset for two cycles and release it on a falling edge.
    task automatic do_reset;
        rst = 1'b0;
        vm = 1'b0; vl = 1'b0; vg = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Reset values on all three instances, then ready after release.
    task automatic test_reset;
        rst = 1'b0;
        vm = 1'b1; vl = 1'b1; vg = 1'b1;
        din = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (x_m !== 1'b0 || x_l !== 1'b0 || x_g !== 1'b0) begin n_err++; $display("[TB] FAIL reset_x: got %b%b%b expected 000", x_m, x_l, x_g); end
        n_vec++; if (xv_m !== 1'b0 || xv_l !== 1'b0 || xv_g !== 1'b0) begin n_err++; $display("[TB] FAIL reset_x_valid: got %b%b%b expected 000", xv_m, xv_l, xv_g); end
        n_vec++; if (rdy_m !== 1'b0 || rdy_l !== 1'b0 || rdy_g !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ready: got %b%b%b expected 000", rdy_m, rdy_l, rdy_g); end
        n_vec++; if (busy_m !== 1'b0 || busy_g !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b%b expected 00", busy_m, busy_g); end
        n_vec++; if (ws_m !== 16'd0 || ws_g !== 16'd0) begin n_err++; $display("[TB] FAIL reset_words: got %0h %0h expected 0 0", ws_m, ws_g); end
        vm = 1'b0; vl = 1'b0; vg = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if (rdy_m !== 1'b1 || rdy_g !== 1'b1) begin n_err++; $display("[TB] FAIL reset_release_ready: got %b%b expected 11", rdy_m, rdy_g); end
        @(negedge clk);
    endtask

    // Single MSB-first word 8'hA5 with a one-cycle valid.
    task automatic test_msb_first;
        logic [7:0] seen;
        do_reset();
        din = 8'hA5; vm = 1'b1;
        n_vec++; if (rdy_m !== 1'b1) begin n_err++; $display("[TB] FAIL msb_ready_idle: got %b expected 1", rdy_m); end
        @(negedge clk);
        vm = 1'b0; din = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            n_vec++; if (xv_m !== 1'b1) begin n_err++; $display("[TB] FAIL msb_x_valid[%0d]: got %b expected 1", k, xv_m); end
            n_vec++; if (rdy_m !== (k == 7)) begin n_err++; $display("[TB] FAIL msb_ready[%0d]: got %b expected %b", k, rdy_m, (k == 7)); end
            seen = {seen[6:0], x_m};
            @(negedge clk);
        end
        n_vec++; if (seen !== 8'hA5) begin n_err++; $display("[TB] FAIL msb_sequence: got %h expected a5", seen); end
        n_vec++; if (x_m !== 1'b0 || xv_m !== 1'b0) begin n_err++; $display("[TB] FAIL msb_after_x: got %b/%b expected 0/0", x_m, xv_m); end
        n_vec++; if (ws_m !== 16'd1) begin n_err++; $display("[TB] FAIL msb_words: got %0d expected 1", ws_m); end
        n_vec++; if (rdy_m !== 1'b1 || busy_m !== 1'b0) begin n_err++; $display("[TB] FAIL msb_after_idle: got ready %b busy %b expected 1 0", rdy_m, busy_m); end
    endtask

    // Single LSB-first word 8'h0D.
    task automatic test_lsb_first;
        logic [7:0] seen;
        do_reset();
        din = 8'h0D; vl = 1'b1;
        @(negedge clk);
        vl = 1'b0; din = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            n_vec++; if (xv_l !== 1'b1) begin n_err++; $display("[TB] FAIL lsb_x_valid[%0d]: got %b expected 1", k, xv_l); end
            seen = {seen[6:0], x_l};
            @(negedge clk);
        end
        n_vec++; if (seen !== 8'hB0) begin n_err++; $display("[TB] FAIL lsb_sequence: got %h expected b0", seen); end
        n_vec++; if (xv_l !== 1'b0 || x_l !== 1'b0) begin n_err++; $display("[TB] FAIL lsb_after_x: got %b/%b expected 0/0", x_l, xv_l); end
        n_vec++; if (ws_l !== 16'd1) begin n_err++; $display("[TB] FAIL lsb_words: got %0d expected 1", ws_l); end
    endtask

    // Two words with valid held high: 16 contiguous bits, ready only on last bits.
    task automatic test_back_to_back;
        logic [15:0] stream;
        stream = 16'hB6DB;
        do_reset();
        din = 8'hB6; vm = 1'b1;
        @(negedge clk);
        din = 8'hDB;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) vm = 1'b0;
            n_vec++; if (xv_m !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_x_valid[%0d]: got %b expected 1", k, xv_m); end
            n_vec++; if (x_m !== stream[15 - k]) begin n_err++; $display("[TB] FAIL b2b_x[%0d]: got %b expected %b", k, x_m, stream[15 - k]); end
            n_vec++; if (rdy_m !== ((k % 8) == 7)) begin n_err++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", k, rdy_m, ((k % 8) == 7)); end
            @(negedge clk);
        end
        n_vec++; if (xv_m !== 1'b0 || rdy_m !== 1'b1 || busy_m !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_idle: got xv %b ready %b busy %b expected 0 1 0", xv_m, rdy_m, busy_m); end
        n_vec++; if (ws_m !== 16'd2) begin n_err++; $display("[TB] FAIL b2b_words: got %0d expected 2", ws_m); end
    endtask

    // GAP=3 instance with valid held: bits, three idle gap cycles, one IDLE cycle.
    task automatic test_gap;
        logic [7:0] w[2];
        w[0] = 8'($urandom);
        w[1] = 8'($urandom);
        do_reset();
        din = w[0]; vg = 1'b1;
        @(negedge clk);
        din = w[1];
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < 12; c++) begin
                if (n == 1 && c == 11) vg = 1'b0;
                if (c < 8) begin
                    n_vec++; if (xv_g !== 1'b1 || x_g !== bit_of(w[n], c, 1'b1)) begin n_err++; $display("[TB] FAIL gap_bit[%0d][%0d]: got %b/%b expected %b/1", n, c, x_g, xv_g, bit_of(w[n], c, 1'b1)); end
                    n_vec++; if (rdy_g !== 1'b0) begin n_err++; $display("[TB] FAIL gap_shift_ready[%0d][%0d]: got %b expected 0", n, c, rdy_g); end
                end else if (c < 11) begin
                    n_vec++; if (x_g !== 1'b0 || xv_g !== 1'b0 || rdy_g !== 1'b0 || busy_g !== 1'b1) begin n_err++; $display("[TB] FAIL gap_idle[%0d][%0d]: got x %b xv %b ready %b busy %b expected 0 0 0 1", n, c, x_g, xv_g, rdy_g, busy_g); end
                end else begin
                    n_vec++; if (rdy_g !== 1'b1 || busy_g !== 1'b0 || xv_g !== 1'b0) begin n_err++; $display("[TB] FAIL gap_ready[%0d]: got ready %b busy %b xv %b expected 1 0 0", n, rdy_g, busy_g, xv_g); end
                    n_vec++; if (ws_g !== 16'(n + 1)) begin n_err++; $display("[TB] FAIL gap_words[%0d]: got %0d expected %0d", n, ws_g, n + 1); end
                end
                @(negedge clk);
            end
        end
        n_vec++; if (xv_g !== 1'b0 || busy_g !== 1'b0) begin n_err++; $display("[TB] FAIL gap_end: got xv %b busy %b expected 0 0", xv_g, busy_g); end
    endtask

    // Asynchronous reset on the 4th bit of 8'hFF clears everything without an edge.
    task automatic test_reset_mid;
        logic [7:0] w;
        do_reset();
        din = 8'h3C; vm = 1'b1;
        @(negedge clk);
        vm = 1'b0;
        repeat (8) @(negedge clk);
        n_vec++; if (ws_m !== 16'd1) begin n_err++; $display("[TB] FAIL rmid_pre_words: got %0d expected 1", ws_m); end
        din = 8'hFF; vm = 1'b1;
        @(negedge clk);
        vm = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (x_m !== 1'b1 || xv_m !== 1'b1 || busy_m !== 1'b1) begin n_err++; $display("[TB] FAIL rmid_fourth_bit: got x %b xv %b busy %b expected 1 1 1", x_m, xv_m, busy_m); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if (x_m !== 1'b0 || xv_m !== 1'b0 || busy_m !== 1'b0) begin n_err++; $display("[TB] FAIL rmid_async: got x %b xv %b busy %b expected 0 0 0", x_m, xv_m, busy_m); end
        n_vec++; if (ws_m !== 16'd0 || rdy_m !== 1'b0) begin n_err++; $display("[TB] FAIL rmid_words_ready: got words %0d ready %b expected 0 0", ws_m, rdy_m); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (rdy_m !== 1'b1) begin n_err++; $display("[TB] FAIL rmid_release_ready: got %b expected 1", rdy_m); end
        @(negedge clk);
        w = 8'($urandom);
        din = w; vm = 1'b1;
        @(negedge clk);
        vm = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_vec++; if (xv_m !== 1'b1 || x_m !== bit_of(w, k, 1'b1)) begin n_err++; $display("[TB] FAIL rmid_new_bit[%0d]: got %b/%b expected %b/1", k, x_m, xv_m, bit_of(w, k, 1'b1)); end
            @(negedge clk);
        end
        n_vec++; if (ws_m !== 16'd1) begin n_err++; $display("[TB] FAIL rmid_new_words: got %0d expected 1", ws_m); end
    endtask

    // Counter preset to 16'hFFFF wraps to zero on the next completed word.
    task automatic test_wrap;
        do_reset();
        force dut_m.words_sent = 16'hFFFF;
        #1;
        release dut_m.words_sent;
        @(negedge clk);
        din = 8'($urandom); vm = 1'b1;
        @(negedge clk);
        vm = 1'b0;
        repeat (7) @(negedge clk);
        n_vec++; if (ws_m !== 16'hFFFF) begin n_err++; $display("[TB] FAIL wrap_before: got %h expected ffff", ws_m); end
        @(negedge clk);
        n_vec++; if (ws_m !== 16'h0000) begin n_err++; $display("[TB] FAIL wrap_after: got %h expected 0000", ws_m); end
    endtask

    // Random words and random valid on both no-gap instances, checked every
    // cycle against a word/position model of the stream.
    task automatic test_random;
        logic ox, oxv, ordy, obusy;
        logic [15:0] ows;
        logic ex, erdy[2];
        bit   v[2];
        do_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0; m_pos[d] = 0; m_cnt[d] = 16'd0; m_word[d] = 8'd0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                ox    = (d == 0) ? x_m    : x_l;
                oxv   = (d == 0) ? xv_m   : xv_l;
                ordy  = (d == 0) ? rdy_m  : rdy_l;
                obusy = (d == 0) ? busy_m : busy_l;
                ows   = (d == 0) ? ws_m   : ws_l;
                ex      = m_act[d] ? bit_of(m_word[d], m_pos[d], (d == 0)) : 1'b0;
                erdy[d] = !m_act[d] || (m_pos[d] == 7);
                n_vec++; if (oxv !== m_act[d]) begin n_err++; $display("[TB] FAIL rnd_x_valid d%0d c%0d: got %b expected %b", d, cyc, oxv, m_act[d]); end
                n_vec++; if (ox !== ex) begin n_err++; $display("[TB] FAIL rnd_x d%0d c%0d: got %b expected %b", d, cyc, ox, ex); end
                n_vec++; if (ordy !== erdy[d]) begin n_err++; $display("[TB] FAIL rnd_ready d%0d c%0d: got %b expected %b", d, cyc, ordy, erdy[d]); end
                n_vec++; if (obusy !== m_act[d]) begin n_err++; $display("[TB] FAIL rnd_busy d%0d c%0d: got %b expected %b", d, cyc, obusy, m_act[d]); end
                n_vec++; if (ows !== m_cnt[d]) begin n_err++; $display("[TB] FAIL rnd_words d%0d c%0d: got %0d expected %0d", d, cyc, ows, m_cnt[d]); end
            end
            din  = 8'($urandom);
            v[0] = ($urandom_range(0, 9) < 7);
            v[1] = ($urandom_range(0, 9) < 4);
            vm = v[0]; vl = v[1];
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (m_act[d] && m_pos[d] == 7) m_cnt[d] = m_cnt[d] + 16'd1;
                if (v[d] && erdy[d]) begin
                    m_word[d] = din; m_pos[d] = 0; m_act[d] = 1'b1;
                end else if (m_act[d]) begin
                    if (m_pos[d] == 7) m_act[d] = 1'b0;
                    else m_pos[d] = m_pos[d] + 1;
                end
            end
        end
        vm = 1'b0; vl = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst = 1'b0;
        din = 8'h00;
        vm = 1'b0; vl = 1'b0; vg = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
